fifo_wr_arbiter: RTL and testbench

- Round-robin, packet-locking arbiter that shares the async FIFO write port among NUM_REQ producers in the write clock domain.
- Selects one requester, holds the grant until that requester's packet ends or a burst limit is reached, and drives the FIFO's w_en/w_data.
- Honours w_full as backpressure.
- Sits directly upstream of the FIFO write block.

---
 rtl/fifo_wr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin, packet-locking arbiter in front of the async FIFO write port.
// One requester at a time owns the port until its packet ends or it has
// written MAX_BURST words. w_full stalls the owner without losing its grant.

`timescale 1ns/1ps

module fifo_wr_arbiter #(
  parameter int bus_width = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                           w_clk,
  input  logic                           w_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*bus_width-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           w_full,
  output logic                           w_en,
  output logic [bus_width-1:0]           w_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  // Beat index of the last word a single grant may carry.
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  // Highest requester index, used to wrap the round-robin pointer.
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  // NUM_REQ in the widened domain used for modulo wrap of candidate indices.
  localparam logic [IDX_W:0]   NR_EXT    = (IDX_W+1)'(NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_reg,    state_next;
  logic [NUM_REQ-1:0]   grant_reg,    grant_next;
  logic [IDX_W-1:0]     owner_reg,    owner_next;
  logic [IDX_W-1:0]     rr_ptr_reg,   rr_ptr_next;
  logic [CNT_W-1:0]     beat_cnt_reg, beat_cnt_next;

  // Per-requester view of the flattened data bus.
  logic [bus_width-1:0] data_arr [NUM_REQ];

  // Candidate at scan offset k is requester (rr_ptr + k) mod NUM_REQ.
  logic [IDX_W-1:0]     cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]   cand_valid;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;

  logic                 owner_valid;
  logic                 owner_last;
  logic                 in_grant;
  logic                 transfer;
  logic                 release_now;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [IDX_W:0] cand_sum;

      assign data_arr[gi] = req_data[gi*bus_width +: bus_width];

      assign cand_sum     = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (cand_sum >= NR_EXT) ? IDX_W'(cand_sum - NR_EXT)
                                                 : IDX_W'(cand_sum);
      assign cand_valid[gi] = req_valid[cand_idx[gi]];

      // Only the current owner is offered ready, and only while the FIFO has room.
      assign req_ready[gi] = grant_reg[gi] & ~w_full;
    end
  endgenerate

  // First valid requester in rotated order; offset 0 (rr_ptr) has top priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  assign in_grant    = (state_reg == GRANT);
  assign owner_valid = req_valid[owner_reg];
  assign owner_last  = req_last[owner_reg];

  // A word moves only when the owner offers one and the FIFO can take it.
  assign transfer    = in_grant && owner_valid && !w_full;

  // The grant ends on the packet's last word or on the word that fills the burst.
  assign release_now = transfer && (owner_last || (beat_cnt_reg == LAST_BEAT));

  // Next-state logic for the IDLE/GRANT controller and its bookkeeping.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next    = GRANT;
          owner_next    = pick_idx;
          grant_next    = NUM_REQ'(1) << pick_idx;
          beat_cnt_next = '0;
        end
      end

      GRANT: begin
        if (transfer) begin
          beat_cnt_next = beat_cnt_reg + CNT_W'(1);
        end
        if (release_now) begin
          state_next    = IDLE;
          grant_next    = '0;
          beat_cnt_next = '0;
          // Releasing owner drops to lowest priority for the next arbitration.
          rr_ptr_next   = (owner_reg == LAST_IDX) ? '0 : owner_reg + IDX_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // Output decode: write port is driven only while a requester owns it.
  always_comb begin
    busy   = in_grant;
    w_en   = transfer;
    w_data = '0;
    if (in_grant) begin
      w_data = data_arr[owner_reg];
    end
  end

  assign grant = grant_reg;

  // State register; reset abandons any packet in flight.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (bus_width=8, NUM_REQ=4, MAX_BURST=4).
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.

`timescale 1ns/1ps

module tb_fifo_wr_arbiter;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        w_full;
  logic        w_en;
  logic [7:0]  w_data;
  logic [3:0]  grant;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] wr_q [$];

  fifo_wr_arbiter #(
    .bus_width (8),
    .NUM_REQ   (4),
    .MAX_BURST (4)
  ) dut (
    .w_clk     (w_clk),
    .w_rst     (w_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .w_full    (w_full),
    .w_en      (w_en),
    .w_data    (w_data),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge w_clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [7:0] val);
    req_data[idx*8 +: 8] = val;
  endtask

  // One line per FIFO write; also guards against writes into a full FIFO.
  always @(negedge w_clk) begin
    if (w_en === 1'b1) begin
      $display("write data=%02h grant=%b full=%b", w_data, grant, w_full);
      wr_q.push_back(w_data);
      chk("no_overflow", {31'd0, w_full}, 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic [7:0] exp_words [4];

    w_rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; w_full = 1'b0;

    // Reset held with every requester valid: reset must win.
    cyc(); req_valid = 4'b1111; #1;
    cyc(); #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wen", w_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wdata", w_data, 0);

    // Test 1: single requester, 3-word packet.
    cyc(); w_rst = 1'b0; req_valid = 4'b0001; req_last = 4'b0000; set_data(0, 8'hA1); #1;
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_ready", req_ready, 0);
    chk("t1_idle_wdata", w_data, 0);
    wr_q.delete();
    cyc(); #1;
    chk("t1_grant", grant, 4'b0001);
    chk("t1_busy", busy, 1);
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_wen1", w_en, 1);
    chk("t1_wdata1", w_data, 8'hA1);
    cyc(); set_data(0, 8'hA2); #1;
    chk("t1_wen2", w_en, 1);
    chk("t1_wdata2", w_data, 8'hA2);
    cyc(); set_data(0, 8'hA3); req_last = 4'b0001; #1;
    chk("t1_wen3", w_en, 1);
    chk("t1_wdata3", w_data, 8'hA3);
    // Requester 1 and 0 both valid now; last flags set but nothing transfers in IDLE.
    cyc(); req_valid = 4'b0011; req_last = 4'b0011; set_data(1, 8'hB1); #1;
    chk("t1_release_grant", grant, 0);
    chk("t1_release_busy", busy, 0);
    chk("t1_release_wen", w_en, 0);
    chk("t1_words", wr_q.size(), 3);
    cyc(); #1;
    chk("t1_rrptr_grant", grant, 4'b0010);
    chk("t1_rrptr_wdata", w_data, 8'hB1);

    // Test 2: all four valid with 1-word packets; rr_ptr is now 2.
    cyc(); req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'h44332211; #1;
    chk("t2_idle_grant", grant, 0);
    for (int k = 0; k < 4; k++) begin
      idx = (2 + k) % 4;
      cyc(); #1;
      chk("t2_grant", grant, 32'(1 << idx));
      chk("t2_wen", w_en, 1);
      chk("t2_wdata", w_data, 32'(8'h11 * (idx + 1)));
      cyc(); #1;
      chk("t2_gap_grant", grant, 0);
      chk("t2_gap_wen", w_en, 0);
    end

    // Test 3: requester 2 (rr_ptr=2) sends 6 words with no last; cap at 4.
    for (int b = 0; b < 4; b++) begin
      cyc(); req_valid = 4'b0100; req_last = 4'b0000; set_data(2, 8'(8'hC1 + b)); #1;
      chk("t3_grant", grant, 4'b0100);
      chk("t3_wen", w_en, 1);
      chk("t3_wdata", w_data, 32'(8'hC1 + b));
    end
    cyc(); req_valid = 4'b1100; req_last = 4'b1000; set_data(3, 8'hD1); set_data(2, 8'hC5); #1;
    chk("t3_cap_release", grant, 0);
    chk("t3_cap_wen", w_en, 0);
    cyc(); #1;
    chk("t3_next_req3", grant, 4'b1000);
    chk("t3_next_ready", req_ready, 4'b1000);
    chk("t3_next_wdata", w_data, 8'hD1);
    cyc(); req_valid = 4'b0100; req_last = 4'b0000; #1;
    chk("t3_idle2", grant, 0);
    cyc(); #1;
    chk("t3_regrant", grant, 4'b0100);
    chk("t3_rem1", w_data, 8'hC5);
    cyc(); set_data(2, 8'hC6); req_last = 4'b0100; #1;
    chk("t3_rem2_wen", w_en, 1);
    chk("t3_rem2", w_data, 8'hC6);

    // Test 4: requester 0 (rr_ptr=3, req 3 idle), 4 words, 3-cycle full stall.
    cyc(); req_valid = 4'b0001; req_last = 4'b0000; set_data(0, 8'hE1); #1;
    chk("t4_idle", grant, 0);
    wr_q.delete();
    cyc(); #1;
    chk("t4_grant", grant, 4'b0001);
    chk("t4_w1", w_data, 8'hE1);
    cyc(); set_data(0, 8'hE2); #1;
    chk("t4_w2_wen", w_en, 1);
    cyc(); set_data(0, 8'hE3); w_full = 1'b1; #1;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) cyc();
      #0;
      chk("t4_stall_wen", w_en, 0);
      chk("t4_stall_ready", req_ready, 0);
      chk("t4_stall_grant", grant, 4'b0001);
    end
    cyc(); w_full = 1'b0; #1;
    chk("t4_w3_wen", w_en, 1);
    chk("t4_w3", w_data, 8'hE3);
    chk("t4_w3_ready", req_ready, 4'b0001);
    cyc(); set_data(0, 8'hE4); #1;
    chk("t4_w4_wen", w_en, 1);
    chk("t4_w4_grant", grant, 4'b0001);
    // No last: the 4th word hits the burst cap only if stalls did not count.
    cyc(); req_valid = 4'b0010; req_last = 4'b0000; set_data(1, 8'hF1); #1;
    chk("t4_release", grant, 0);
    chk("t4_words", wr_q.size(), 4);
    exp_words[0] = 8'hE1; exp_words[1] = 8'hE2; exp_words[2] = 8'hE3; exp_words[3] = 8'hE4;
    for (int i = 0; i < 4; i++) begin
      if (i < wr_q.size()) chk("t4_word", wr_q[i], exp_words[i]);
    end

    // Test 5: requester 1 (rr_ptr=1), reset after its 2nd word.
    cyc(); #1;
    chk("t5_grant", grant, 4'b0010);
    chk("t5_w1", w_data, 8'hF1);
    cyc(); set_data(1, 8'hF2); #1;
    chk("t5_w2_wen", w_en, 1);
    cyc(); set_data(1, 8'hF3); w_rst = 1'b1; #1;
    cyc(); w_rst = 1'b0; req_valid = 4'b0011; req_last = 4'b0011; set_data(0, 8'h61); #1;
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_wen", w_en, 0);
    cyc(); #1;
    chk("t5_restart_idx0", grant, 4'b0001);
    chk("t5_restart_wdata", w_data, 8'h61);

    // Test 6: requester 1 (rr_ptr=1) stalls its own packet for 5 cycles.
    cyc(); req_valid = 4'b0010; req_last = 4'b0000; set_data(1, 8'h71); #1;
    chk("t6_idle", grant, 0);
    cyc(); #1;
    chk("t6_grant", grant, 4'b0010);
    chk("t6_w1", w_data, 8'h71);
    cyc(); req_valid = 4'b1101; #1;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) cyc();
      #0;
      chk("t6_hold_grant", grant, 4'b0010);
      chk("t6_hold_wen", w_en, 0);
      chk("t6_hold_ready", req_ready, 4'b0010);
      chk("t6_hold_busy", busy, 1);
    end
    cyc(); req_valid = 4'b1111; req_last = 4'b0010; set_data(1, 8'h72); #1;
    chk("t6_resume_wen", w_en, 1);
    chk("t6_resume_wdata", w_data, 8'h72);
    cyc(); #1;
    chk("t6_release", grant, 0);
    cyc(); #1;
    chk("t6_next_grant", grant, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
